// File: rtl/mc_control_fsm.sv
// Multi-cycle Moore control unit for the 16-bit accumulator processor.
// Define MC_CTRL_HALT_ON_ILLEGAL_EN to halt on illegal opcodes (default: treat as NOP).
module mc_control_fsm (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] instr,
  input  logic        zero,
  output logic        pwrite,
  output logic        iwrite,
  output logic        regwrite,
  output logic        memwrite,
  output logic        adrsrc,
  output logic        memtoreg,
  output logic        alusrca,
  output logic        regdest,
  output logic [1:0]  alusrcb,
  output logic [2:0]  alucontrol,
  output logic        halted,
  output logic [3:0]  dbg_state
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEM_ADR = 4'd2,
    S_MEM_RD  = 4'd3,
    S_WB_MEM  = 4'd4,
    S_MEM_WR  = 4'd5,
    S_JUMP    = 4'd6,
    S_BZ_TEST = 4'd7,
    S_BZ_TAKE = 4'd8,
    S_EXEC    = 4'd9,
    S_WB_ALU  = 4'd10,
    S_HALT    = 4'd11
  } state_t;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_AND   = 3'b010;
  localparam logic [2:0] ALU_OR    = 3'b011;
  localparam logic [2:0] ALU_NOTB  = 3'b100;
  localparam logic [2:0] ALU_PASSA = 3'b101;
  localparam logic [2:0] ALU_PASSB = 3'b110;

  state_t     state_q, state_d;
  logic       zflag_q, zflag_d;
  logic [3:0] opcode;
  logic       unused_instr_bits;

  assign opcode            = instr[15:12];
  assign unused_instr_bits = ^instr[11:0];
  assign dbg_state         = state_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_FETCH;
      zflag_q <= 1'b0;
    end else begin
      state_q <= state_d;
      zflag_q <= zflag_d;
    end
  end

  // Branch condition is latched at the BZ_TEST edge so later zero glitches are ignored.
  assign zflag_d = (state_q == S_BZ_TEST) ? zero : zflag_q;

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          4'b0000, 4'b0001: state_d = S_MEM_ADR;
          4'b0010:          state_d = S_JUMP;
          4'b0100:          state_d = S_BZ_TEST;
          4'b1000, 4'b1001, 4'b1010, 4'b1011,
          4'b1100, 4'b1101, 4'b1110: state_d = S_EXEC;
          4'b1111:          state_d = S_FETCH;
`ifdef MC_CTRL_HALT_ON_ILLEGAL_EN
          default:          state_d = S_HALT;
`else
          default:          state_d = S_FETCH;
`endif
        endcase
      end
      S_MEM_ADR: state_d = (opcode == 4'b0000) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:  state_d = S_WB_MEM;
      S_BZ_TEST: state_d = S_BZ_TAKE;
      S_EXEC:    state_d = S_WB_ALU;
`ifdef MC_CTRL_HALT_ON_ILLEGAL_EN
      S_HALT:    state_d = S_HALT;
`endif
      default:   state_d = S_FETCH;
    endcase
  end

  always_comb begin
    pwrite     = 1'b0;
    iwrite     = 1'b0;
    regwrite   = 1'b0;
    memwrite   = 1'b0;
    adrsrc     = 1'b0;
    memtoreg   = 1'b0;
    alusrca    = 1'b0;
    regdest    = 1'b0;
    alusrcb    = 2'b00;
    alucontrol = ALU_ADD;
    case (state_q)
      S_FETCH: begin
        iwrite  = 1'b1;
        pwrite  = 1'b1;
        alusrcb = 2'b01;
      end
      S_MEM_ADR: begin
        alusrcb    = 2'b10;
        alucontrol = ALU_PASSB;
      end
      S_MEM_RD: begin
        adrsrc     = 1'b1;
        alusrcb    = 2'b10;
        alucontrol = ALU_PASSB;
      end
      S_WB_MEM: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
      end
      S_MEM_WR: begin
        adrsrc     = 1'b1;
        memwrite   = 1'b1;
        alusrcb    = 2'b10;
        alucontrol = ALU_PASSB;
      end
      S_JUMP: begin
        alusrcb    = 2'b10;
        alucontrol = ALU_PASSB;
        pwrite     = 1'b1;
      end
      S_BZ_TEST: begin
        alusrca    = 1'b1;
        alucontrol = ALU_PASSA;
      end
      S_BZ_TAKE: begin
        alusrcb    = 2'b10;
        alucontrol = ALU_PASSB;
        pwrite     = zflag_q;
      end
      S_EXEC: begin
        alusrca = 1'b1;
        case (opcode)
          4'b1000: alucontrol = ALU_PASSA;
          4'b1001: alucontrol = ALU_PASSB;
          4'b1011: alucontrol = ALU_SUB;
          4'b1100: alucontrol = ALU_AND;
          4'b1101: alucontrol = ALU_OR;
          4'b1110: alucontrol = ALU_NOTB;
          default: alucontrol = ALU_ADD;
        endcase
      end
      S_WB_ALU: begin
        regwrite = 1'b1;
        regdest  = (opcode == 4'b1000);
      end
      default: ;
    endcase
  end

`ifdef MC_CTRL_HALT_ON_ILLEGAL_EN
  assign halted = (state_q == S_HALT);
`else
  assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_mc_control_fsm.sv
// Self-checking bench for mc_control_fsm: vector table, corner sequences, random program.
module tb_mc_control_fsm;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] instr = 16'hF000;
  logic        zero = 1'b0;
  logic        pwrite, iwrite, regwrite, memwrite, adrsrc, memtoreg, alusrca, regdest;
  logic [1:0]  alusrcb;
  logic [2:0]  alucontrol;
  logic        halted;
  logic [3:0]  dbg_state;

  int checks = 0;
  int failures = 0;

  mc_control_fsm dut (
    .clk(clk), .rst(rst), .instr(instr), .zero(zero),
    .pwrite(pwrite), .iwrite(iwrite), .regwrite(regwrite), .memwrite(memwrite),
    .adrsrc(adrsrc), .memtoreg(memtoreg), .alusrca(alusrca), .regdest(regdest),
    .alusrcb(alusrcb), .alucontrol(alucontrol), .halted(halted), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // Output word: {pw,iw,rw,mw,adrsrc,memtoreg,alusrca,regdest,alusrcb[1:0],alucontrol[2:0],halted}
  function automatic logic [13:0] mk(input bit pw, input bit iw, input bit rw, input bit mw,
                                     input bit as, input bit mr, input bit sa, input bit rd,
                                     input bit [1:0] sb, input bit [2:0] ac, input bit h);
    return {pw, iw, rw, mw, as, mr, sa, rd, sb, ac, h};
  endfunction

  logic [13:0] v_fetch, v_decode, v_mem_adr, v_mem_rd, v_wb_mem, v_mem_wr, v_jump;
  logic [13:0] v_bz_test, v_halt;
  logic [13:0] exp_q[$];

  function automatic logic [13:0] v_bz_take(input bit z);
    return mk(z, 0, 0, 0, 0, 0, 0, 0, 2'b10, 3'b110, 0);
  endfunction

  function automatic logic [13:0] v_exec(input logic [3:0] op);
    logic [2:0] ops [7];
    ops = '{3'b101, 3'b110, 3'b000, 3'b001, 3'b010, 3'b011, 3'b100};
    return mk(0, 0, 0, 0, 0, 0, 1, 0, 2'b00, ops[op - 4'd8], 0);
  endfunction

  function automatic logic [13:0] v_wb_alu(input bit moveto);
    return mk(0, 0, 1, 0, 0, 0, 0, moveto, 2'b00, 3'b000, 0);
  endfunction

  function automatic logic [13:0] actual();
    return {pwrite, iwrite, regwrite, memwrite, adrsrc, memtoreg, alusrca, regdest,
            alusrcb, alucontrol, halted};
  endfunction

  task automatic check(input string name, input logic [13:0] exp);
    logic [13:0] act;
    act = actual();
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: the micro-step list an instruction walks through, FETCH first.
  function automatic void push_seq(input logic [15:0] ins, input bit z_at_test);
    logic [3:0] op;
    op = ins[15:12];
    exp_q.push_back(v_fetch);
    exp_q.push_back(v_decode);
    if (op == 4'd0) begin
      exp_q.push_back(v_mem_adr); exp_q.push_back(v_mem_rd); exp_q.push_back(v_wb_mem);
    end else if (op == 4'd1) begin
      exp_q.push_back(v_mem_adr); exp_q.push_back(v_mem_wr);
    end else if (op == 4'd2) begin
      exp_q.push_back(v_jump);
    end else if (op == 4'd4) begin
      exp_q.push_back(v_bz_test); exp_q.push_back(v_bz_take(z_at_test));
    end else if (op >= 4'd8 && op <= 4'd14) begin
      exp_q.push_back(v_exec(op)); exp_q.push_back(v_wb_alu(op == 4'd8));
    end
  endfunction

  typedef struct {
    logic [15:0] instr;
    logic        zero;
    logic [13:0] exp;
    string       name;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input logic [15:0] i, input logic z, input logic [13:0] e, input string n);
    vec_t v;
    v.instr = i; v.zero = z; v.exp = e; v.name = n;
    tbl.push_back(v);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    v_fetch   = mk(1, 1, 0, 0, 0, 0, 0, 0, 2'b01, 3'b000, 0);
    v_decode  = 14'd0;
    v_mem_adr = mk(0, 0, 0, 0, 0, 0, 0, 0, 2'b10, 3'b110, 0);
    v_mem_rd  = mk(0, 0, 0, 0, 1, 0, 0, 0, 2'b10, 3'b110, 0);
    v_wb_mem  = mk(0, 0, 1, 0, 0, 1, 0, 0, 2'b00, 3'b000, 0);
    v_mem_wr  = mk(0, 0, 0, 1, 1, 0, 0, 0, 2'b10, 3'b110, 0);
    v_jump    = mk(1, 0, 0, 0, 0, 0, 0, 0, 2'b10, 3'b110, 0);
    v_bz_test = mk(0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 3'b101, 0);
    v_halt    = mk(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 3'b000, 1);

    add(16'h0005, 0, v_fetch,   "load_fetch");
    add(16'h0005, 0, v_decode,  "load_decode");
    add(16'h0005, 0, v_mem_adr, "load_mem_adr");
    add(16'h0005, 1, v_mem_rd,  "load_mem_rd");
    add(16'h0005, 0, v_wb_mem,  "load_wb_mem");
    add(16'h1005, 0, v_fetch,   "store_fetch");
    add(16'h1005, 1, v_decode,  "store_decode");
    add(16'h1005, 0, v_mem_adr, "store_mem_adr");
    add(16'h1005, 0, v_mem_wr,  "store_mem_wr");
    add(16'h4010, 0, v_fetch,   "bz1_fetch");
    add(16'h4010, 0, v_decode,  "bz1_decode");
    add(16'h4010, 1, v_bz_test, "bz1_test");
    add(16'h4010, 0, mk(1, 0, 0, 0, 0, 0, 0, 0, 2'b10, 3'b110, 0), "bz1_take");
    add(16'h4010, 1, v_fetch,   "bz0_fetch");
    add(16'h4010, 1, v_decode,  "bz0_decode");
    add(16'h4010, 0, v_bz_test, "bz0_test");
    add(16'h4010, 1, mk(0, 0, 0, 0, 0, 0, 0, 0, 2'b10, 3'b110, 0), "bz0_take");
    add(16'h8600, 0, v_fetch,   "moveto_fetch");
    add(16'h8600, 0, v_decode,  "moveto_decode");
    add(16'h8600, 0, mk(0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 3'b101, 0), "moveto_exec");
    add(16'h8600, 0, mk(0, 0, 1, 0, 0, 0, 0, 1, 2'b00, 3'b000, 0), "moveto_wb");
    add(16'hB600, 0, v_fetch,   "sub_fetch");
    add(16'hB600, 0, v_decode,  "sub_decode");
    add(16'hB600, 0, mk(0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 3'b001, 0), "sub_exec");
    add(16'hB600, 0, mk(0, 0, 1, 0, 0, 0, 0, 0, 2'b00, 3'b000, 0), "sub_wb");
    add(16'hF000, 0, v_fetch,   "nop_fetch");
    add(16'hF000, 0, v_decode,  "nop_decode");
    add(16'h2003, 0, v_fetch,   "jump_fetch");
    add(16'h2003, 0, v_decode,  "jump_decode");
    add(16'h2003, 0, v_jump,    "jump_jump");
    add(16'hF000, 0, v_fetch,   "after_jump_fetch");

    // Reset state, while rst is still high.
    @(negedge clk);
    check("reset_state", v_fetch);
    do_reset();

    foreach (tbl[i]) begin
      instr = tbl[i].instr;
      zero  = tbl[i].zero;
      check(tbl[i].name, tbl[i].exp);
      @(negedge clk);
    end

    // Reset asserted in MEM_WR must drop memwrite without waiting for a clock.
    instr = 16'h1005;
    check("mw_decode", v_decode);
    @(negedge clk);
    check("mw_mem_adr", v_mem_adr);
    @(negedge clk);
    check("mw_mem_wr", v_mem_wr);
    #2 rst = 1'b1;
    #1 check("mw_async_abort", v_fetch);
    @(negedge clk);
    rst = 1'b0;

    // Illegal opcode.
    instr = 16'h5000;
    check("ill_fetch", v_fetch);
    @(negedge clk);
    check("ill_decode", v_decode);
    @(negedge clk);
`ifdef MC_CTRL_HALT_ON_ILLEGAL_EN
    for (int c = 0; c < 20; c++) begin
      zero = 1'($urandom_range(0, 1));
      check($sformatf("ill_halt_%0d", c), v_halt);
      @(negedge clk);
    end
    do_reset();
    check("ill_recover", v_fetch);
`else
    check("ill_as_nop_fetch", v_fetch);
`endif

    // Random program against the micro-step model.
    for (int n = 0; n < 200; n++) begin
      logic [15:0] ins;
      bit          zs [6];
      int          k;
      ins = 16'($urandom());
`ifdef MC_CTRL_HALT_ON_ILLEGAL_EN
      if (ins[15:12] inside {4'd3, 4'd5, 4'd6, 4'd7}) ins[15:12] = 4'hF;
`endif
      foreach (zs[j]) zs[j] = 1'($urandom_range(0, 1));
      instr = ins;
      push_seq(ins, zs[2]);
      k = 0;
      while (exp_q.size() > 0) begin
        logic [13:0] e;
        e = exp_q.pop_front();
        zero = zs[k];
        check($sformatf("rnd_%0d_op%h_step%0d", n, ins[15:12], k), e);
        k++;
        @(negedge clk);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
